// File: rtl/chunked_ripple_adder_pkg.sv
// Shared types and helpers for the chunked ripple adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;

  // A chunk counter needs at least one bit even when there is a single chunk
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_ripple_adder_if.sv
// Operand/result handshake bundle for the chunked ripple adder.
interface chunked_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/chunked_ripple_adder_chunk.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into
// its top bit so the caller can form the signed-overflow term.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] cy;

  assign cy[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign cout  = cy[CHUNK];
  assign c_msb = cy[CHUNK-1];
endmodule

// File: rtl/chunked_ripple_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, carry held in a
// register between slices, valid/ready on both sides.
module chunked_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  chunked_ripple_adder_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_ripple_adder: WIDTH must be a multiple of CHUNK");
  end

  add_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IW-1:0]    idx_q;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout, ch_c_msb;
  logic             last;

  assign last = (idx_q == IW'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[int'(idx_q)*CHUNK +: CHUNK]),
    .b     (b_q[int'(idx_q)*CHUNK +: CHUNK]),
    .cin   (carry_q),
    .sum   (ch_sum),
    .cout  (ch_cout),
    .c_msb (ch_c_msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted on capture and the +1 rides in on the carry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.in_a;
          b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
          idx_q   <= '0;
        end
        RUN: begin
          sum_q[int'(idx_q)*CHUNK +: CHUNK] <= ch_sum;
          carry_q <= ch_cout;
          if (last) begin
            idx_q  <= '0;
            cout_q <= ch_cout;
            ovf_q  <= ch_cout ^ ch_c_msb;
          end else begin
            idx_q  <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Directed table plus corner sequences and random ops against CHUNK=4 and CHUNK=16 instances.
module tb_chunked_ripple_adder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  chunked_ripple_adder_if #(.WIDTH(W)) bus4 ();
  chunked_ripple_adder_if #(.WIDTH(W)) bus16 ();

  chunked_ripple_adder #(.WIDTH(W), .CHUNK(4))  u_dut4  (.clk(clk), .reset(reset), .bus(bus4));
  chunked_ripple_adder #(.WIDTH(W), .CHUNK(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));

  typedef struct {
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    bus4.in_a = a;   bus4.in_b = b;   bus4.in_cin = cin;   bus4.in_sub = sub;
    bus16.in_a = a;  bus16.in_b = b;  bus16.in_cin = cin;  bus16.in_sub = sub;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int n;
    n = 0;
    set_ops(a, b, cin, sub);
    while (!(bus4.in_ready && bus16.in_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_timeout", 32'(n < 50), 32'd1);
    bus4.in_valid = 1'b1; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0; bus16.in_valid = 1'b0;
  endtask

  // Runs one op on both instances and leaves both sitting in DONE with out_ready low
  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic cin, input logic sub,
                    input logic [W-1:0] esum, input logic ecout, input logic eovf);
    int l4, l16;
    l4 = 0; l16 = 0;
    start(a, b, cin, sub);
    // the accepting edge has just passed; count edges until out_valid shows
    if (bus4.out_valid)  l4 = 0;
    for (int k = 1; k <= 40 && (l4 == 0 || l16 == 0); k++) begin
      if (k > 1 || 1) begin
        @(posedge clk); #1;
      end
      if (l4 == 0 && bus4.out_valid)   l4 = k;
      if (l16 == 0 && bus16.out_valid) l16 = k;
    end
    check({name, "/lat4"},  32'(l4),  32'd4);
    check({name, "/lat16"}, 32'(l16), 32'd1);
    check({name, "/sum4"},   32'(bus4.out_sum),   32'(esum));
    check({name, "/cout4"},  32'(bus4.out_cout),  32'(ecout));
    check({name, "/ovf4"},   32'(bus4.out_ovf),   32'(eovf));
    check({name, "/sum16"},  32'(bus16.out_sum),  32'(esum));
    check({name, "/cout16"}, 32'(bus16.out_cout), 32'(ecout));
    check({name, "/ovf16"},  32'(bus16.out_ovf),  32'(eovf));
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    bus4.out_ready = 1'b1; bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0; bus16.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W:0]   full;
    logic [W-1:0] ra, rb, bb;
    logic         rsub, rcin, eovf;

    bus4.in_valid = 1'b0;  bus4.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    set_ops('0, '0, 1'b0, 1'b0);

    vecs[0] = '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    // reset state while reset is still asserted
    #2;
    check("rst/out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst/sum",       32'(bus4.out_sum),   32'd0);
    check("rst/flags",     32'({bus4.out_cout, bus4.out_ovf}), 32'd0);
    check("rst/in_ready",  32'(bus4.in_ready),  32'd1);
    @(posedge clk); #1 reset = 1'b0;

    foreach (vecs[i]) begin
      op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
         vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      release_out(i % 3);
    end

    // stall in DONE: outputs frozen and a stray in_valid is dropped
    op("stall", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    held = bus4.out_sum;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        set_ops(16'h1234, 16'h1111, 1'b0, 1'b0);
        bus4.in_valid = 1'b1; bus16.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus4.in_valid = 1'b0; bus16.in_valid = 1'b0;
      check("stall/out_valid", 32'(bus4.out_valid), 32'd1);
      check("stall/sum",       32'(bus4.out_sum),   32'(held));
      check("stall/in_ready",  32'(bus4.in_ready),  32'd0);
    end
    release_out(0);
    op("after_stall", 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
    release_out(0);

    // leave flags set, then reset part-way through a run
    op("preflags", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    release_out(0);
    start(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("midrun/partial", 32'(bus4.out_sum[3:0]), 32'h3);
    reset = 1'b1;
    #1;
    check("midrst/out_valid", 32'(bus4.out_valid), 32'd0);
    check("midrst/sum",       32'(bus4.out_sum),   32'd0);
    check("midrst/flags",     32'({bus4.out_cout, bus4.out_ovf}), 32'd0);
    check("midrst/sum16",     32'(bus16.out_sum),  32'd0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("midrst/in_ready",  32'(bus4.in_ready),  32'd1);
    op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    release_out(1);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rsub = 1'($urandom); rcin = 1'($urandom);
      bb   = rsub ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + 17'(rsub ? 1'b1 : rcin);
      eovf = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
      op("rand", ra, rb, rcin, rsub, full[W-1:0], full[W], eovf);
      release_out(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
